// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, refill, stall and memory-bus signals around mem_port_arbiter.
// The master view belongs to the arbiter. The slave view belongs to the pipeline and memory side.
interface mem_port_arbiter_if #(
  parameter int LINE_WORDS = 4
);
  localparam int IDX_W = $clog2(LINE_WORDS);

  logic             if_req;
  logic [31:0]      if_addr;
  logic             if_rvalid;
  logic [IDX_W-1:0] if_word_idx;
  logic [31:0]      if_rdata;
  logic             if_done;

  logic             d_req;
  logic             d_we;
  logic [31:0]      d_addr;
  logic [31:0]      d_wdata;
  logic [31:0]      d_rdata;
  logic             d_done;

  logic             stall_if;
  logic             stall_mem;

  logic             mem_en;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rvalid, if_word_idx, if_rdata, if_done, d_rdata, d_done,
           stall_if, stall_mem, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rvalid, if_word_idx, if_rdata, if_done, d_rdata, d_done,
           stall_if, stall_mem, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between I-cache line refills and single-beat data loads/stores.
// When both sides request at once, the grant alternates between them.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 3,
  parameter int LINE_WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.master bus
);
  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] I_ISSUE = 3'd1;
  localparam logic [2:0] I_DRAIN = 3'd2;
  localparam logic [2:0] D_READ  = 3'd3;
  localparam logic [2:0] D_WRITE = 3'd4;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0] LAT_CNT   = CNT_W'(MEM_LAT);
  localparam logic [31:0]      LINE_MASK = 32'(LINE_WORDS * 4 - 1);

  logic [2:0]                    state_q, state_d;
  logic                          last_grant_q, last_grant_d;
  logic [IDX_W-1:0]              issue_idx_q, issue_idx_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [MEM_LAT-1:0]            ret_vld_q, ret_vld_d;
  logic [MEM_LAT-1:0][IDX_W-1:0] ret_idx_q, ret_idx_d;

  logic        i_issue, d_issue, d_wr_issue;
  logic        if_done, d_done;
  logic [31:0] line_base;

  assign i_issue    = (state_q == I_ISSUE);
  assign d_issue    = ((state_q == D_READ) || (state_q == D_WRITE)) && (cnt_q == '0);
  assign d_wr_issue = (state_q == D_WRITE) && (cnt_q == '0);
  assign d_done     = ((state_q == D_READ)  && (cnt_q == LAT_CNT)) ||
                      ((state_q == D_WRITE) && (cnt_q == CNT_W'(1)));
  assign if_done    = ret_vld_q[MEM_LAT-1] && (ret_idx_q[MEM_LAT-1] == LAST_IDX);
  assign line_base  = bus.if_addr & ~LINE_MASK;

  always_comb begin
    // NOTE: each _d starts from its held value, so every path assigns it and no latch is inferred.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    issue_idx_d  = issue_idx_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.if_req && (!bus.d_req || (last_grant_q == GRANT_D))) begin
          state_d      = I_ISSUE;
          issue_idx_d  = '0;
          last_grant_d = GRANT_I;
        end else if (bus.d_req) begin
          state_d      = bus.d_we ? D_WRITE : D_READ;
          cnt_d        = '0;
          last_grant_d = GRANT_D;
        end
      end
      I_ISSUE: begin
        issue_idx_d = issue_idx_q + IDX_W'(1);
        if (issue_idx_q == LAST_IDX) state_d = I_DRAIN;
      end
      I_DRAIN: begin
        if (if_done) state_d = IDLE;
      end
      D_READ, D_WRITE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (d_done) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Each issued refill word reappears at the far end of this pipe exactly MEM_LAT cycles later.
  always_comb begin
    ret_vld_d    = '0;
    ret_idx_d    = '0;
    ret_vld_d[0] = i_issue;
    ret_idx_d[0] = issue_idx_q;
    for (int i = 1; i < MEM_LAT; i++) begin
      ret_vld_d[i] = ret_vld_q[i-1];
      ret_idx_d[i] = ret_idx_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments, so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      issue_idx_q  <= '0;
      cnt_q        <= '0;
      ret_vld_q    <= '0;
      ret_idx_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      issue_idx_q  <= issue_idx_d;
      cnt_q        <= cnt_d;
      ret_vld_q    <= ret_vld_d;
      ret_idx_q    <= ret_idx_d;
    end
  end

  always_comb begin
    bus.mem_addr = '0;
    if (i_issue)      bus.mem_addr = line_base | 32'({issue_idx_q, 2'b00});
    else if (d_issue) bus.mem_addr = bus.d_addr;
  end

  assign bus.mem_en      = i_issue | d_issue;
  assign bus.mem_we      = d_wr_issue;
  assign bus.mem_wdata   = d_wr_issue ? bus.d_wdata : '0;

  assign bus.if_rvalid   = ret_vld_q[MEM_LAT-1];
  assign bus.if_word_idx = ret_idx_q[MEM_LAT-1];
  assign bus.if_rdata    = ret_vld_q[MEM_LAT-1] ? bus.mem_rdata : '0;
  assign bus.if_done     = if_done;

  assign bus.d_done      = d_done;
  assign bus.d_rdata     = d_done ? bus.mem_rdata : '0;

  assign bus.stall_if    = bus.if_req & ~if_done;
  assign bus.stall_mem   = bus.d_req & ~d_done;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter. Expected memory issues, refill beats and data completions
// are queued with their due cycle when stimulus is applied, and a negedge monitor pops and compares them.
module tb_mem_port_arbiter;
  localparam int MEM_LAT    = 3;
  localparam int LINE_WORDS = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  typedef struct {
    int          cyc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_exp_t;

  typedef struct {
    int          cyc;
    logic [31:0] idx;
    logic [31:0] data;
    logic        done;
  } ifr_exp_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        chk_data;
  } d_exp_t;

  mem_exp_t exp_mem[$];
  ifr_exp_t exp_ifr[$];
  d_exp_t   exp_d[$];
  mem_exp_t m_got;
  ifr_exp_t r_got;
  d_exp_t   d_got;

  logic [31:0] rd_pipe [MEM_LAT];

  mem_port_arbiter_if #(.LINE_WORDS(LINE_WORDS)) bus ();

  mem_port_arbiter #(
    .MEM_LAT    (MEM_LAT),
    .LINE_WORDS (LINE_WORDS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: a read returns its own address MEM_LAT cycles after issue.
  initial for (int i = 0; i < MEM_LAT; i++) rd_pipe[i] = '0;
  always @(posedge clk) begin
    rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ? bus.mem_addr : 32'h0;
    for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_rdata = rd_pipe[MEM_LAT-1];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got 0x%08h expected 0x%08h", tag, cyc, act, exp);
  endtask

  task automatic at_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_refill(input int tg, input logic [31:0] base);
    for (int k = 0; k < LINE_WORDS; k++) begin
      exp_mem.push_back('{tg + 1 + k, 1'b0, base + 32'(4 * k), 32'h0});
      exp_ifr.push_back('{tg + 1 + k + MEM_LAT, 32'(k), base + 32'(4 * k), (k == LINE_WORDS - 1)});
    end
  endtask

  task automatic push_load(input int t, input logic [31:0] addr);
    exp_mem.push_back('{t + 1, 1'b0, addr, 32'h0});
    exp_d.push_back('{t + 1 + MEM_LAT, addr, 1'b1});
  endtask

  task automatic push_store(input int t, input logic [31:0] addr, input logic [31:0] data);
    exp_mem.push_back('{t + 1, 1'b1, addr, data});
    exp_d.push_back('{t + 2, 32'h0, 1'b0});
  endtask

  always @(negedge clk) begin
    if (bus.mem_en) begin
      if (exp_mem.size() == 0) check("mem_unexpected", 32'(bus.mem_en), 0);
      else begin
        m_got = exp_mem.pop_front();
        check("mem_cycle", 32'(cyc), 32'(m_got.cyc));
        check("mem_we", 32'(bus.mem_we), 32'(m_got.we));
        check("mem_addr", bus.mem_addr, m_got.addr);
        if (m_got.we) check("mem_wdata", bus.mem_wdata, m_got.wdata);
      end
    end else begin
      check("idle_we", 32'(bus.mem_we), 0);
      check("idle_addr", bus.mem_addr, 0);
      check("idle_wdata", bus.mem_wdata, 0);
    end

    if (bus.if_rvalid) begin
      if (exp_ifr.size() == 0) check("ifr_unexpected", 32'(bus.if_rvalid), 0);
      else begin
        r_got = exp_ifr.pop_front();
        check("ifr_cycle", 32'(cyc), 32'(r_got.cyc));
        check("ifr_idx", 32'(bus.if_word_idx), r_got.idx);
        check("ifr_data", bus.if_rdata, r_got.data);
        check("if_done", 32'(bus.if_done), 32'(r_got.done));
      end
    end else if (bus.if_done) begin
      check("if_done_alone", 32'(bus.if_done), 0);
    end

    if (bus.d_done) begin
      if (exp_d.size() == 0) check("d_unexpected", 32'(bus.d_done), 0);
      else begin
        d_got = exp_d.pop_front();
        check("d_cycle", 32'(cyc), 32'(d_got.cyc));
        if (d_got.chk_data) check("d_rdata", bus.d_rdata, d_got.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    rst_n       = 1'b0;

    // Reset state
    at_cycle(2);
    @(negedge clk);
    check("rst_mem_en", 32'(bus.mem_en), 0);
    check("rst_if_rvalid", 32'(bus.if_rvalid), 0);
    check("rst_if_done", 32'(bus.if_done), 0);
    check("rst_d_done", 32'(bus.d_done), 0);
    check("rst_if_rdata", bus.if_rdata, 0);
    check("rst_d_rdata", bus.d_rdata, 0);
    check("rst_stall_if", 32'(bus.stall_if), 0);
    check("rst_stall_mem", 32'(bus.stall_mem), 0);
    at_cycle(3);
    rst_n = 1'b1;

    // Simultaneous requests right after reset: D first, then I
    t = 5;
    at_cycle(t);
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_2000;
    bus.d_req  = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0100;
    push_load(t, 32'h0000_0100);
    push_refill(t + 5, 32'h0000_2000);
    at_cycle(t + 3);
    @(negedge clk);
    check("conf_stall_if_wait", 32'(bus.stall_if), 1);
    at_cycle(t + 5);
    bus.d_req = 1'b0;
    at_cycle(t + 13);
    bus.if_req = 1'b0;

    // D load
    t = t + 15;
    at_cycle(t);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0080;
    push_load(t, 32'h0000_0080);
    at_cycle(t + 3);
    @(negedge clk);
    check("load_stall_mem_busy", 32'(bus.stall_mem), 1);
    at_cycle(t + 4);
    @(negedge clk);
    check("load_stall_mem_done", 32'(bus.stall_mem), 0);
    at_cycle(t + 5);
    bus.d_req = 1'b0;

    // Second simultaneous pair, last grant was D: I first, then D store
    t = t + 7;
    at_cycle(t);
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_3008;
    bus.d_req  = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0000_0044; bus.d_wdata = 32'h1234_5678;
    push_refill(t, 32'h0000_3000);
    push_store(t + 8, 32'h0000_0044, 32'h1234_5678);
    at_cycle(t + 8);
    bus.if_req = 1'b0;
    at_cycle(t + 11);
    bus.d_req = 1'b0; bus.d_we = 1'b0;

    // D store
    t = t + 13;
    at_cycle(t);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0000_0040; bus.d_wdata = 32'hDEAD_BEEF;
    push_store(t, 32'h0000_0040, 32'hDEAD_BEEF);
    at_cycle(t + 3);
    bus.d_req = 1'b0; bus.d_we = 1'b0;

    // I refill with stall profile
    t = t + 5;
    at_cycle(t);
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_1234;
    push_refill(t, 32'h0000_1230);
    for (int c = 0; c < 8; c++) begin
      at_cycle(t + c);
      @(negedge clk);
      check($sformatf("stall_if_c%0d", c), 32'(bus.stall_if), (c < 7) ? 1 : 0);
    end
    at_cycle(t + 8);
    bus.if_req = 1'b0;

    // Top-of-memory line, no wrap past 0xFFFF_FFFC
    t = t + 10;
    at_cycle(t);
    bus.if_req = 1'b1; bus.if_addr = 32'hFFFF_FFF8;
    push_refill(t, 32'hFFFF_FFF0);
    at_cycle(t + 8);
    bus.if_req = 1'b0;

    // Reset during a refill: in-flight returns vanish, refill restarts from word 0
    t = t + 10;
    at_cycle(t);
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_1234;
    for (int k = 0; k < 3; k++) exp_mem.push_back('{t + 1 + k, 1'b0, 32'h0000_1230 + 32'(4 * k), 32'h0});
    at_cycle(t + 3);
    rst_n = 1'b0;
    at_cycle(t + 4);
    @(negedge clk);
    check("mid_rst_mem_en", 32'(bus.mem_en), 0);
    check("mid_rst_if_rvalid", 32'(bus.if_rvalid), 0);
    check("mid_rst_if_done", 32'(bus.if_done), 0);
    at_cycle(t + 5);
    rst_n = 1'b1;
    push_refill(t + 5, 32'h0000_1230);
    at_cycle(t + 13);
    bus.if_req = 1'b0;
    at_cycle(t + 16);

    check("left_mem", 32'(exp_mem.size()), 0);
    check("left_ifr", 32'(exp_ifr.size()), 0);
    check("left_d", 32'(exp_d.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
